// File: rtl/flag_controller.sv
// flag_controller
//   Write-port sequencer/arbiter for the 8-bit processor status register P.
//   It merges four update sources into per-bit write enables and data:
//   ALU flag results, explicit set/clear, stack pulls and interrupt/BRK entry.
//   It also detects NMI edges, masks IRQ with the I flag, formats the status
//   byte for pushes (BRK/IRQ/NMI entry and PHP) and initialises P after reset.
//
//   Optional build macro: FLAG_CTRL_CMOS_DCLR_EN
//     defined   -> interrupt/BRK entry also clears D (65C02 behaviour)
//     undefined -> D is left untouched on entry (NMOS behaviour)
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   p_q[7:0]                   current P register contents
//   alu_valid/alu_mask/alu_flags   ALU flag update request
//   sc_valid/sc_bit/sc_val     explicit set/clear of one bit
//   pull_valid/pull_data       P loaded from the stack
//   brk_req, php_req           single-cycle instruction pulses
//   nmi_n, irq_n, int_ack      interrupt lines and core acknowledge
//   ena[7:0], d[7:0]           registered per-bit write enable / data to P
//   int_req, int_is_nmi        interrupt pending / NMI vector select
//   push_valid, push_data[7:0] registered stack write of the status byte
//   busy                       sequencer is not idle
module flag_controller #(
    parameter logic [7:0] P_INIT = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] p_q,
    input  logic       alu_valid,
    input  logic [7:0] alu_mask,
    input  logic [7:0] alu_flags,
    input  logic       sc_valid,
    input  logic [2:0] sc_bit,
    input  logic       sc_val,
    input  logic       pull_valid,
    input  logic [7:0] pull_data,
    input  logic       brk_req,
    input  logic       php_req,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       int_ack,
    output logic [7:0] ena,
    output logic [7:0] d,
    output logic       int_req,
    output logic       int_is_nmi,
    output logic       push_valid,
    output logic [7:0] push_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PUSH = 2'd2,
        ST_SETI = 2'd3
    } state_t;

    // Bits 5 and 4 of P are not real storage, so a pull never writes them.
    localparam logic [7:0] PULL_MASK = 8'hCF;
    localparam logic [7:0] SETI_D    = 8'h04;
`ifdef FLAG_CTRL_CMOS_DCLR_EN
    localparam logic [7:0] SETI_ENA  = 8'h0C;   // set I, clear D
`else
    localparam logic [7:0] SETI_ENA  = 8'h04;   // set I only
`endif

    state_t     state;
    logic       nmi_prev;      // nmi_n from the previous cycle
    logic       nmi_latch;     // falling edge seen, not yet serviced
    logic       push_b;        // B bit for the pending entry push
    logic       nmi_svc;       // current entry is servicing the NMI

    logic       in_idle;
    logic       nmi_fall;
    logic       nmi_clear;
    logic [7:0] pull_en;
    logic [7:0] sc_en;
    logic [7:0] alu_en;
    logic [7:0] arb_ena;
    logic [7:0] arb_d;

    assign in_idle   = (state == ST_IDLE);
    assign nmi_fall  = nmi_prev & ~nmi_n;
    assign nmi_clear = (state == ST_SETI) & nmi_svc;

    assign int_req    = in_idle & (nmi_latch | (~irq_n & ~p_q[2]));
    // While idle this reports what would be serviced; once an entry has
    // started it reports the value captured at acknowledge.
    assign int_is_nmi = in_idle ? nmi_latch : nmi_svc;
    assign busy       = ~in_idle;

    assign pull_en = pull_valid ? PULL_MASK : 8'h00;
    assign sc_en   = sc_valid ? (8'h01 << sc_bit) : 8'h00;
    assign alu_en  = alu_valid ? alu_mask : 8'h00;

    // Per-bit arbitration: enables are OR-ed, data comes from the
    // highest-priority source (pull > set/clear > ALU) that enables the bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_arb
            assign arb_ena[gi] = pull_en[gi] | sc_en[gi] | alu_en[gi];
            assign arb_d[gi]   = pull_en[gi] ? pull_data[gi] :
                                 sc_en[gi]   ? sc_val        :
                                 alu_en[gi]  ? alu_flags[gi] : 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            ena        <= 8'h00;
            d          <= 8'h00;
            push_valid <= 1'b0;
            push_data  <= 8'h00;
            nmi_prev   <= 1'b1;
            nmi_latch  <= 1'b0;
            push_b     <= 1'b0;
            nmi_svc    <= 1'b0;
        end else begin
            nmi_prev <= nmi_n;
            // A new edge arriving while the latch is cleared still wins.
            nmi_latch <= (nmi_latch & ~nmi_clear) | nmi_fall;

            ena        <= 8'h00;
            d          <= 8'h00;
            push_valid <= 1'b0;

            case (state)
                ST_INIT: begin
                    ena   <= 8'hFF;
                    d     <= P_INIT;
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    ena <= arb_ena;
                    d   <= arb_d;
                    if (php_req) begin
                        push_valid <= 1'b1;
                        push_data  <= p_q | 8'h30;
                    end
                    if (brk_req) begin
                        state   <= ST_PUSH;
                        push_b  <= 1'b1;
                        nmi_svc <= 1'b0;
                    end else if (int_ack && int_req) begin
                        state   <= ST_PUSH;
                        push_b  <= 1'b0;
                        nmi_svc <= nmi_latch;
                    end
                end
                ST_PUSH: begin
                    push_valid <= 1'b1;
                    push_data  <= {p_q[7:6], 1'b1, push_b, p_q[3:0]};
                    state      <= ST_SETI;
                end
                ST_SETI: begin
                    ena   <= SETI_ENA;
                    d     <= SETI_D;
                    state <= ST_IDLE;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_controller.sv
// Testbench for flag_controller: directed literal checks followed by a
// randomized run compared every cycle against a behavioural model.
module tb_flag_controller;

    localparam logic [7:0] P_INIT = 8'h34;
`ifdef FLAG_CTRL_CMOS_DCLR_EN
    localparam logic [7:0] ENTRY_ENA = 8'h0C;
`else
    localparam logic [7:0] ENTRY_ENA = 8'h04;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] p_q;
    logic       alu_valid;
    logic [7:0] alu_mask;
    logic [7:0] alu_flags;
    logic       sc_valid;
    logic [2:0] sc_bit;
    logic       sc_val;
    logic       pull_valid;
    logic [7:0] pull_data;
    logic       brk_req;
    logic       php_req;
    logic       nmi_n;
    logic       irq_n;
    logic       int_ack;
    logic [7:0] ena;
    logic [7:0] d;
    logic       int_req;
    logic       int_is_nmi;
    logic       push_valid;
    logic [7:0] push_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    flag_controller #(.P_INIT(P_INIT)) dut (
        .clk(clk), .reset(reset), .p_q(p_q),
        .alu_valid(alu_valid), .alu_mask(alu_mask), .alu_flags(alu_flags),
        .sc_valid(sc_valid), .sc_bit(sc_bit), .sc_val(sc_val),
        .pull_valid(pull_valid), .pull_data(pull_data),
        .brk_req(brk_req), .php_req(php_req),
        .nmi_n(nmi_n), .irq_n(irq_n), .int_ack(int_ack),
        .ena(ena), .d(d), .int_req(int_req), .int_is_nmi(int_is_nmi),
        .push_valid(push_valid), .push_data(push_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_init: first cycle after reset release still pending.
    // m_left: cycles remaining in an interrupt/BRK entry (push, then set I).
    bit         m_init = 1'b1;
    int         m_left = 0;
    bit         m_b    = 1'b0;
    bit         m_svc  = 1'b0;
    bit         m_pend = 1'b0;
    bit         m_prev = 1'b1;
    logic [7:0] exp_ena   = 8'h00;
    logic [7:0] exp_d     = 8'h00;
    logic       exp_pv    = 1'b0;
    logic [7:0] exp_pdata = 8'h00;

    // Compare process: outputs are stable at the falling edge (inputs move
    // 2 time units after the rising edge); check, then advance the model
    // to what the next rising edge must produce.
    always @(negedge clk) begin
        logic busy_e;
        logic ireq_e;
        logic nmi_e;
        logic new_pend;
        if (reset) begin
            m_init = 1'b1; m_left = 0; m_b = 1'b0; m_svc = 1'b0;
            m_pend = 1'b0; m_prev = 1'b1;
            exp_ena = 8'h00; exp_d = 8'h00; exp_pv = 1'b0; exp_pdata = 8'h00;
        end
        busy_e = m_init || (m_left != 0);
        ireq_e = !busy_e && (m_pend || (!irq_n && !p_q[2]));
        nmi_e  = busy_e ? m_svc : m_pend;

        chk("ena", ena, exp_ena);
        chk("d", d, exp_d);
        chk1("push_valid", push_valid, exp_pv);
        if (exp_pv) chk("push_data", push_data, exp_pdata);
        chk1("busy", busy, busy_e);
        chk1("int_req", int_req, ireq_e);
        chk1("int_is_nmi", int_is_nmi, nmi_e);

        if (!reset) begin
            new_pend = (m_pend && !(m_left == 1 && m_svc)) || (m_prev && !nmi_n);
            exp_pv  = 1'b0;
            exp_ena = 8'h00;
            exp_d   = 8'h00;
            if (m_init) begin
                exp_ena = 8'hFF;
                exp_d   = P_INIT;
                m_init  = 1'b0;
            end else if (m_left == 2) begin
                exp_pv       = 1'b1;
                exp_pdata    = p_q | 8'h20;
                exp_pdata[4] = m_b;
                m_left       = 1;
            end else if (m_left == 1) begin
                exp_ena = ENTRY_ENA;
                exp_d   = 8'h04;
                m_left  = 0;
            end else begin
                // Apply sources lowest priority first so later ones overwrite.
                if (alu_valid) begin
                    exp_ena = exp_ena | alu_mask;
                    exp_d   = alu_flags & alu_mask;
                end
                if (sc_valid) begin
                    exp_ena[sc_bit] = 1'b1;
                    exp_d[sc_bit]   = sc_val;
                end
                if (pull_valid) begin
                    exp_ena = exp_ena | 8'hCF;
                    exp_d   = (exp_d & 8'h30) | (pull_data & 8'hCF);
                end
                if (php_req) begin
                    exp_pv    = 1'b1;
                    exp_pdata = p_q | 8'h30;
                end
                if (brk_req) begin
                    m_left = 2; m_b = 1'b1; m_svc = 1'b0;
                end else if (int_ack && ireq_e) begin
                    m_left = 2; m_b = 1'b0; m_svc = m_pend;
                end
            end
            m_pend = new_pend;
            m_prev = nmi_n;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
        #3;
    endtask

    task automatic quiet();
        pull_valid = 1'b0; sc_valid = 1'b0; alu_valid = 1'b0;
        brk_req = 1'b0; php_req = 1'b0; int_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; p_q = 8'h24; nmi_n = 1'b1; irq_n = 1'b1;
        alu_mask = 8'h00; alu_flags = 8'h00; sc_bit = 3'd0; sc_val = 1'b0;
        pull_data = 8'h00;
        quiet();

        repeat (3) step();
        look();
        chk("rst_ena", ena, 8'h00);
        chk1("rst_busy", busy, 1'b1);
        step(); reset = 1'b0;                       // INIT cycle
        look(); chk1("init_busy", busy, 1'b1);
        step(); look();
        chk("init_ena", ena, 8'hFF);
        chk("init_d", d, 8'h34);
        chk1("idle_busy", busy, 1'b0);
        step(); look();
        chk("idle_ena", ena, 8'h00);

        // Stack pull: bits 5/4 untouched.
        step(); p_q = 8'h24; pull_valid = 1'b1; pull_data = 8'hFF;
        step(); quiet(); look();
        chk("pull_ena", ena, 8'hCF);
        chk("pull_d", d & 8'hCF, 8'hCF);

        // Set/clear on bit 0 beats ALU on bit 0; ALU keeps bits 7 and 1.
        step(); sc_valid = 1'b1; sc_bit = 3'd0; sc_val = 1'b0;
        alu_valid = 1'b1; alu_mask = 8'h83; alu_flags = 8'hFF;
        step(); quiet(); look();
        chk("scalu_ena", ena, 8'h83);
        chk("scalu_d", d & 8'h83, 8'h82);

        // IRQ masked by I, then serviced once I is clear.
        step(); p_q = 8'h24; irq_n = 1'b0;
        look(); chk1("irq_masked", int_req, 1'b0);
        step(); p_q = 8'h20; int_ack = 1'b1;
        look(); chk1("irq_req", int_req, 1'b1); chk1("irq_not_nmi", int_is_nmi, 1'b0);
        step(); int_ack = 1'b0;                    // PUSH
        step(); look();                            // SETI
        chk1("irq_pv", push_valid, 1'b1);
        chk("irq_push", push_data, 8'h20);
        step(); p_q = 8'h24; irq_n = 1'b1; look();
        chk("irq_seti_ena", ena, ENTRY_ENA);
        chk("irq_seti_d", d, 8'h04);

        // NMI edge while IRQ also pending.
        step(); p_q = 8'h20; irq_n = 1'b0; nmi_n = 1'b0;
        step(); int_ack = 1'b1; look();
        chk1("nmi_sel", int_is_nmi, 1'b1);
        step(); int_ack = 1'b0; look();
        chk1("nmi_held", int_is_nmi, 1'b1);
        step(); look();
        chk("nmi_push", push_data, 8'h20);
        step(); p_q = 8'h24; look();
        chk1("nmi_cleared_req", int_req, 1'b0);
        chk1("nmi_cleared_sel", int_is_nmi, 1'b0);
        step(); nmi_n = 1'b1; irq_n = 1'b1;

        // BRK push formatting.
        step(); p_q = 8'hC1; brk_req = 1'b1;
        step(); brk_req = 1'b0;
        step(); look();
        chk("brk_push", push_data, 8'hF1);
        step(); look();
        chk("brk_seti_ena", ena, ENTRY_ENA);
        chk("brk_seti_d", d, 8'h04);

        // Reset during PUSH aborts the entry.
        step(); brk_req = 1'b1;
        step(); brk_req = 1'b0; reset = 1'b1;
        look(); chk1("abort_pv", push_valid, 1'b0); chk1("abort_busy", busy, 1'b1);
        step(); look(); chk1("abort_pv2", push_valid, 1'b0);
        step(); reset = 1'b0;

        // Randomized phase.
        repeat (4000) begin
            step();
            reset      = ($urandom_range(0, 399) == 0);
            p_q        = 8'($urandom);
            pull_valid = ($urandom_range(0, 5) == 0);
            pull_data  = 8'($urandom);
            sc_valid   = ($urandom_range(0, 3) == 0);
            sc_bit     = 3'($urandom_range(0, 7));
            sc_val     = 1'($urandom);
            alu_valid  = ($urandom_range(0, 1) == 0);
            alu_mask   = 8'($urandom);
            alu_flags  = 8'($urandom);
            brk_req    = ($urandom_range(0, 19) == 0);
            php_req    = ($urandom_range(0, 9) == 0);
            int_ack    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 4) == 0) irq_n = ~irq_n;
        end
        step();
        reset = 1'b0;
        quiet();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flag_controller.md
Name: flag_controller

Overview:
- Sequencer and write-port arbiter for the 8-bit processor status register (P).
- Drives the register's per-bit write enables and write data from four sources: ALU flag results, explicit set/clear instructions, stack pulls (PLP/RTI) and interrupt/BRK entry.
- Also performs NMI edge detection, IRQ masking by the I flag, status-byte formatting for pushes, and post-reset P initialisation.
- Sits between the instruction decoder/ALU and the status register.

Parameters:
- P_INIT, 8'h34, value written to P in the INIT cycle after reset (I=1, B=1, bit5=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_q  in  8  current P register contents.
- alu_valid  in  1  ALU flag update this cycle.
- alu_mask  in  8  bits of P the ALU writes.
- alu_flags  in  8  ALU flag values.
- sc_valid  in  1  explicit set/clear (SEC/CLC/SEI/CLI/SED/CLD/CLV).
- sc_bit  in  3  target bit index.
- sc_val  in  1  value to write.
- pull_valid  in  1  P loaded from stack (PLP/RTI).
- pull_data  in  8  byte pulled from stack.
- brk_req  in  1  single-cycle pulse, BRK executing.
- php_req  in  1  single-cycle pulse, PHP executing.
- nmi_n  in  1  NMI line, active low; synchronised externally.
- irq_n  in  1  IRQ line, active low, level.
- int_ack  in  1  core accepts a pending interrupt at an instruction boundary.
- ena  out  8  per-bit write enable to P.
- d  out  8  write data to P.
- int_req  out  1  interrupt pending.
- int_is_nmi  out  1  pending/serviced interrupt is NMI (vector select).
- push_valid  out  1  push_data valid for the stack write.
- push_data  out  8  formatted status byte.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async): state=INIT; ena, d, push_valid, push_data, int_req, int_is_nmi = 0; NMI latch cleared; nmi_n history register set to 1.
- Registered outputs: ena, d, push_valid, push_data. Update source in cycle N → P changes at end of cycle N+1.
- FSM states: INIT, IDLE, PUSH, SETI.
- INIT: one cycle after reset release; ena=8'hFF, d=P_INIT; → IDLE. All requests during INIT are ignored.
- IDLE:
  - brk_req → PUSH with B=1.
  - int_ack while int_req=1 → PUSH with B=0.
  - brk_req takes precedence over int_ack when both are asserted.
- PUSH (1 cycle): push_valid=1; push_data = p_q with bit5=1 and bit4=B; → SETI.
- SETI (1 cycle): ena[2]=1, d[2]=1 (I set). If servicing NMI, clear the NMI latch. → IDLE.
- php_req in IDLE: push_valid=1 next cycle; push_data = p_q | 8'h30; no state change.
- Per-bit write arbitration in IDLE, highest priority first: pull, set/clear, ALU.
  - ena[i] = OR of the enables of all active sources.
  - d[i] comes from the highest-priority source enabling bit i.
  - Pull: enables 8'hCF, so bits 5 and 4 are never written from the stack.
  - Set/clear: enables bit sc_bit only.
  - ALU: enables alu_mask.
  - Example: sc_valid on bit 0 with alu_mask=8'h83 → bit 0 from sc_val, bits 7 and 1 from ALU.
- During PUSH and SETI: all pull, set/clear and ALU requests are dropped (not queued). The decoder guarantees none are issued there.
- NMI edge detect: latch set when the previous nmi_n=1 and the current nmi_n=0. A new falling edge while the latch is already set is merged with it.
- int_req = nmi_latch | (~irq_n & ~p_q[2]), evaluated combinationally in IDLE; forced to 0 in other states.
- int_is_nmi = nmi_latch; captured at int_ack and held through SETI.
- IRQ masking:
  - IRQ is masked by p_q as currently held. An SEI write landing in the same cycle as int_ack does not retract that acknowledge.
  - IRQ deasserted before int_ack → int_req drops, no service.
- Reset mid-sequence (PUSH/SETI): abort with no push_valid; re-enter INIT.

Optional Feature:
- Macro: FLAG_CTRL_CMOS_DCLR_EN.
- Defined: SETI also sets ena[3]=1, d[3]=0, clearing D on BRK/IRQ/NMI entry (65C02 behaviour).
- Undefined: D is untouched on interrupt entry (NMOS behaviour).

Test Plan:
- Release reset → one cycle with ena=FF, d=34; then ena=00, busy=0.
- In IDLE with p_q=8'h24, pull_valid with pull_data=8'hFF → ena=CF, d[7:6]=11, d[3:0]=1111.
- sc_valid bit0 val0 and alu_valid mask=83 flags=FF in the same cycle → ena=83, d[7]=1, d[1]=1, d[0]=0.
- IRQ low with p_q[2]=1 → int_req=0. Clear I (p_q=8'h20) → int_req=1, int_is_nmi=0. int_ack → push_data=8'h20 → next cycle ena[2]=1, d[2]=1.
- nmi_n falls while irq_n is low → int_is_nmi=1. int_ack → push_data has bit4=0. Latch cleared after SETI, so int_req follows the IRQ/I state only.
- brk_req with p_q=8'hC1 → push_data=8'hF1. SETI sets I; D is cleared only with FLAG_CTRL_CMOS_DCLR_EN defined. Reset asserted during PUSH → no push_valid, state INIT.
